// File: rtl/fifo_pkg.sv
// Shared sizing helpers and threshold legality check for the parametrised sync FIFO.
// Imported by the top level so every file derives depth and pointer width the same way.
package fifo_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_ADDR_W = 4;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int v = value - 1; v > 0; v = v >> 1) r++;
    return r;
  endfunction

  function automatic int fifo_depth(input int addr_w);
    return 1 << addr_w;
  endfunction

  // One extra wrap bit beyond the memory address distinguishes full from empty.
  function automatic int ptr_width(input int depth);
    return clog2(depth) + 1;
  endfunction

  localparam int DEF_DEPTH = fifo_depth(DEF_ADDR_W);

  function automatic bit thresholds_ok(input int ae, input int af, input int depth);
    return (ae >= 0) && (ae < af) && (af <= depth);
  endfunction

endpackage

// File: rtl/sdp_ram.sv
// Simple dual-port register array: synchronous write port, asynchronous read port.
// Contents are deliberately left unreset.
module sdp_ram #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/fifo_sync_param.sv
// Parametrised synchronous FIFO with true-full detection, occupancy count, programmable
// almost-full/almost-empty thresholds, sticky overflow/underflow flags and optional FWFT read.
module fifo_sync_param
  import fifo_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 4,
  parameter int AF_LEVEL = 2**ADDR_W - 2,
  parameter int AE_LEVEL = 2,
  parameter int FWFT     = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wrt_sig,
  input  logic              rd_sig,
  input  logic [DATA_W-1:0] din,
  input  logic              err_clr,
  output logic [DATA_W-1:0] dout,
  output logic              full_sig,
  output logic              empty_sig,
  output logic              almost_full,
  output logic              almost_empty,
  output logic [ADDR_W:0]   count,
  output logic              over_flow,
  output logic              under_flow
);

  localparam int DEPTH = fifo_depth(ADDR_W);
  localparam int PTR_W = ptr_width(DEPTH);

  if (!thresholds_ok(AE_LEVEL, AF_LEVEL, DEPTH)) begin : g_bad_thresholds
    $error("fifo_sync_param: thresholds must satisfy 0 <= AE_LEVEL < AF_LEVEL <= DEPTH");
  end

  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              wr_acc;
  logic              rd_acc;
  logic [DATA_W-1:0] rdata;

  // Status is decoded from the registered pointers; count wraps modulo 2**PTR_W.
  assign count        = wr_ptr - rd_ptr;
  assign full_sig     = (count == PTR_W'(DEPTH));
  assign empty_sig    = (count == '0);
  assign almost_full  = (count >= PTR_W'(AF_LEVEL));
  assign almost_empty = (count <= PTR_W'(AE_LEVEL));

  // Requests are ignored while reset is held so memory is never touched on a reset edge.
  assign wr_acc = wrt_sig & ~full_sig  & ~rst;
  assign rd_acc = rd_sig  & ~empty_sig & ~rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + PTR_W'(1);
      if (rd_acc) rd_ptr <= rd_ptr + PTR_W'(1);
    end
  end

  // A new violation on the same edge as err_clr keeps the flag set.
  always_ff @(posedge clk) begin
    if (rst) begin
      over_flow  <= 1'b0;
      under_flow <= 1'b0;
    end else begin
      if (wrt_sig && full_sig)  over_flow <= 1'b1;
      else if (err_clr)         over_flow <= 1'b0;
      if (rd_sig && empty_sig)  under_flow <= 1'b1;
      else if (err_clr)         under_flow <= 1'b0;
    end
  end

  sdp_ram #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk   (clk),
    .we    (wr_acc),
    .waddr (wr_ptr[ADDR_W-1:0]),
    .wdata (din),
    .raddr (rd_ptr[ADDR_W-1:0]),
    .rdata (rdata)
  );

  if (FWFT == 0) begin : g_std
    logic [DATA_W-1:0] dout_p1;

    // Registered read stage: the word is captured on the accepting edge.
    always_ff @(posedge clk) begin
      if (rst)         dout_p1 <= '0;
      else if (rd_acc) dout_p1 <= rdata;
    end

    assign dout = dout_p1;
  end else begin : g_fwft
    // Head of queue is presented directly; zero while nothing is held.
    assign dout = empty_sig ? '0 : rdata;
  end

endmodule

// File: tb/tb_fifo_sync_param.sv
// Directed bench for fifo_sync_param: standard-read instance checked against a queue model
// plus hand-computed vectors, and a fall-through instance checked with direct vectors.
module tb_fifo_sync_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Standard-read instance
  logic       rst_a, wrt_a, rd_a, clr_a;
  logic [7:0] din_a, dout_a;
  logic       full_a, empty_a, af_a, ae_a, ovf_a, uf_a;
  logic [4:0] count_a;

  // Fall-through instance
  logic       rst_b, wrt_b, rd_b, clr_b;
  logic [7:0] din_b, dout_b;
  logic       full_b, empty_b, af_b, ae_b, ovf_b, uf_b;
  logic [4:0] count_b;

  fifo_sync_param #(.DATA_W(8), .ADDR_W(4), .FWFT(0)) dut_a (
    .clk(clk), .rst(rst_a), .wrt_sig(wrt_a), .rd_sig(rd_a), .din(din_a), .err_clr(clr_a),
    .dout(dout_a), .full_sig(full_a), .empty_sig(empty_a), .almost_full(af_a),
    .almost_empty(ae_a), .count(count_a), .over_flow(ovf_a), .under_flow(uf_a)
  );

  fifo_sync_param #(.DATA_W(8), .ADDR_W(4), .FWFT(1)) dut_b (
    .clk(clk), .rst(rst_b), .wrt_sig(wrt_b), .rd_sig(rd_b), .din(din_b), .err_clr(clr_b),
    .dout(dout_b), .full_sig(full_b), .empty_sig(empty_b), .almost_full(af_b),
    .almost_empty(ae_b), .count(count_b), .over_flow(ovf_b), .under_flow(uf_b)
  );

  int vectors    = 0;
  int miscompares = 0;

  logic [7:0] q[$];
  logic [7:0] m_dout;
  logic       m_ovf, m_uf;

  task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One clock on instance A with the reference queue stepped alongside it.
  task automatic cycle_a(input logic w, input logic r, input logic [7:0] d, input logic c);
    bit f, e;
    int n;
    f = (q.size() == 16);
    e = (q.size() == 0);
    wrt_a = w; rd_a = r; din_a = d; clr_a = c;
    tick();
    wrt_a = 1'b0; rd_a = 1'b0; clr_a = 1'b0;
    if (r && !e) m_dout = q.pop_front();
    if (w && !f) q.push_back(d);
    if (w && f) m_ovf = 1'b1; else if (c) m_ovf = 1'b0;
    if (r && e) m_uf  = 1'b1; else if (c) m_uf  = 1'b0;
    n = q.size();
    expect_eq("a_dout",  dout_a,  m_dout);
    expect_eq("a_count", count_a, n);
    expect_eq("a_full",  full_a,  n == 16);
    expect_eq("a_empty", empty_a, n == 0);
    expect_eq("a_af",    af_a,    n >= 14);
    expect_eq("a_ae",    ae_a,    n <= 2);
    expect_eq("a_ovf",   ovf_a,   m_ovf);
    expect_eq("a_uf",    uf_a,    m_uf);
  endtask

  initial begin
    rst_a = 1'b1; wrt_a = 1'b0; rd_a = 1'b0; clr_a = 1'b0; din_a = '0;
    rst_b = 1'b1; wrt_b = 1'b0; rd_b = 1'b0; clr_b = 1'b0; din_b = '0;
    m_dout = '0; m_ovf = 1'b0; m_uf = 1'b0;
    tick(); tick();
    rst_a = 1'b0; rst_b = 1'b0;
    tick();

    // Reset state
    expect_eq("rst_empty", empty_a, 1'b1);
    expect_eq("rst_full",  full_a,  1'b0);
    expect_eq("rst_count", count_a, 5'd0);
    expect_eq("rst_ae",    ae_a,    1'b1);
    expect_eq("rst_af",    af_a,    1'b0);
    expect_eq("rst_ovf",   ovf_a,   1'b0);
    expect_eq("rst_uf",    uf_a,    1'b0);
    expect_eq("rst_dout",  dout_a,  8'h00);

    // Fill 0x00..0x0F
    for (int i = 0; i < 16; i++) cycle_a(1'b1, 1'b0, 8'(i), 1'b0);
    expect_eq("fill_full",  full_a,  1'b1);
    expect_eq("fill_count", count_a, 5'd16);

    // Overflow at full, then clear
    cycle_a(1'b1, 1'b0, 8'hAA, 1'b0);
    expect_eq("ovf_set",   ovf_a,   1'b1);
    expect_eq("ovf_count", count_a, 5'd16);
    cycle_a(1'b0, 1'b0, 8'h00, 1'b1);
    expect_eq("ovf_clr", ovf_a, 1'b0);

    // Drain: dout follows 0x00..0x0F one cycle after each read
    for (int i = 0; i < 16; i++) begin
      cycle_a(1'b0, 1'b1, 8'h00, 1'b0);
      expect_eq("drain_dout", dout_a, 8'(i));
    end
    expect_eq("drain_empty", empty_a, 1'b1);

    // Underflow holds dout; set wins over a simultaneous clear
    cycle_a(1'b0, 1'b1, 8'h00, 1'b0);
    expect_eq("uf_set",  uf_a,   1'b1);
    expect_eq("uf_dout", dout_a, 8'h0F);
    cycle_a(1'b0, 1'b1, 8'h00, 1'b1);
    expect_eq("uf_setwins", uf_a, 1'b1);
    cycle_a(1'b0, 1'b0, 8'h00, 1'b1);
    expect_eq("uf_clr", uf_a, 1'b0);
    cycle_a(1'b1, 1'b0, 8'h55, 1'b0);
    cycle_a(1'b0, 1'b1, 8'h00, 1'b0);
    expect_eq("uf_dout55", dout_a, 8'h55);

    // Simultaneous read/write at count 5 for 40 cycles
    for (int i = 0; i < 5; i++) cycle_a(1'b1, 1'b0, 8'(8'h80 + i), 1'b0);
    for (int i = 0; i < 40; i++) cycle_a(1'b1, 1'b1, 8'(8'hC0 + i), 1'b0);
    expect_eq("rw5_count", count_a, 5'd5);
    expect_eq("rw5_dout",  dout_a,  8'hC0 + 8'd34);

    // Simultaneous at full: write rejected, count 15
    for (int i = 0; i < 11; i++) cycle_a(1'b1, 1'b0, 8'(8'h10 + i), 1'b0);
    cycle_a(1'b1, 1'b1, 8'hEE, 1'b0);
    expect_eq("rwfull_count", count_a, 5'd15);
    expect_eq("rwfull_ovf",   ovf_a,   1'b1);
    cycle_a(1'b0, 1'b0, 8'h00, 1'b1);

    // Simultaneous at empty: read rejected, count 1
    for (int i = 0; i < 15; i++) cycle_a(1'b0, 1'b1, 8'h00, 1'b0);
    cycle_a(1'b1, 1'b1, 8'h77, 1'b0);
    expect_eq("rwempty_count", count_a, 5'd1);
    expect_eq("rwempty_uf",    uf_a,    1'b1);
    cycle_a(1'b0, 1'b1, 8'h00, 1'b0);
    expect_eq("rwempty_dout", dout_a, 8'h77);

    // Fall-through instance
    expect_eq("b_rst_empty", empty_b, 1'b1);
    wrt_b = 1'b1; din_b = 8'h3C;
    tick();
    wrt_b = 1'b0;
    expect_eq("b_dout3c", dout_b,  8'h3C);
    expect_eq("b_nempty", empty_b, 1'b0);
    tick();
    expect_eq("b_hold3c", dout_b, 8'h3C);
    rd_b = 1'b1;
    tick();
    rd_b = 1'b0;
    expect_eq("b_popempty", empty_b, 1'b1);
    for (int i = 0; i < 9; i++) begin
      wrt_b = 1'b1; din_b = 8'(8'h20 + i);
      tick();
    end
    wrt_b = 1'b0;
    expect_eq("b_count9", count_b, 5'd9);
    expect_eq("b_head",   dout_b,  8'h20);
    rst_b = 1'b1; wrt_b = 1'b1; din_b = 8'hFF;
    tick();
    rst_b = 1'b0; wrt_b = 1'b0;
    expect_eq("b_rst_count", count_b, 5'd0);
    expect_eq("b_rst_empty2", empty_b, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fifo_sync_param.md
Name: fifo_sync_param

Overview:
Parametrised synchronous FIFO. Next generation of the team's byte FIFO. Generalised in data width and depth, with true-full detection (all DEPTH entries usable) and pointer protection on overflow/underflow. Adds an occupancy count, programmable almost-full/almost-empty thresholds, sticky error flags and a selectable first-word-fall-through (FWFT) read mode. Sits between any producer/consumer pair in the same clock domain.

Parameters:
DATA_W, 8, data word width in bits
ADDR_W, 4, address width; DEPTH = 2**ADDR_W entries
AF_LEVEL, 2**ADDR_W-2, almost_full asserts when count >= AF_LEVEL
AE_LEVEL, 2, almost_empty asserts when count <= AE_LEVEL
FWFT, 0, 0 = standard registered read; 1 = first-word-fall-through

Ports:
clk  in  1  clock; all logic on rising edge
rst  in  1  synchronous reset, active-high
wrt_sig  in  1  write request
rd_sig  in  1  read request
din  in  DATA_W  write data
err_clr  in  1  clears sticky error flags
dout  out  DATA_W  read data
full_sig  out  1  count == DEPTH
empty_sig  out  1  count == 0
almost_full  out  1  count >= AF_LEVEL
almost_empty  out  1  count <= AE_LEVEL
count  out  ADDR_W+1  occupancy, 0..DEPTH
over_flow  out  1  sticky: write attempted while full
under_flow  out  1  sticky: read attempted while empty

Behaviour:
- One clock (clk). Reset is synchronous and active-high (rst), sampled on the rising edge of clk.
- Reset values: wr_ptr=0, rd_ptr=0, count=0, empty_sig=1, full_sig=0, almost_empty=1, almost_full=(AF_LEVEL==0), over_flow=0, under_flow=0, dout=0. Memory contents are not reset.
- Reset asserted mid-operation discards all contents on that edge; wrt_sig/rd_sig are ignored while rst=1.
- Pointers are ADDR_W+1 bits. The low ADDR_W bits address memory; the MSB is a wrap bit. count = wr_ptr - rd_ptr, modulo 2**(ADDR_W+1).
- full_sig, empty_sig, almost_full, almost_empty and count are combinational from the registered pointers. All of them update in the cycle after the accepting edge.
- Write accept: wr_acc = wrt_sig & ~full_sig. On wr_acc, mem[wr_ptr] <= din and wr_ptr increments. Wrap from DEPTH-1 to 0 toggles the MSB.
- Read accept: rd_acc = rd_sig & ~empty_sig. On rd_acc, rd_ptr increments.
- A rejected request never moves a pointer and never corrupts memory.
- Simultaneous accepted read and write: both pointers advance and count is unchanged.
  - When full, only the read is accepted; the write is rejected and sets over_flow.
  - When empty, only the write is accepted; the read is rejected and sets under_flow.
- over_flow is set on any edge with wrt_sig & full_sig. under_flow is set on any edge with rd_sig & empty_sig.
- err_clr clears both flags on the next edge. If a set and err_clr occur on the same edge, set wins.
- FWFT=0 (standard mode):
  - On rd_acc, dout <= mem[rd_ptr], visible the cycle after the accepting edge (1-cycle latency).
  - dout holds its value otherwise, including on rejected reads.
- FWFT=1 (fall-through mode):
  - dout = mem[rd_ptr] combinationally and is valid whenever empty_sig=0.
  - rd_sig acknowledges (pops) the displayed word.
  - A write into an empty FIFO shows on dout the cycle after the write edge.
  - dout is don't-care while empty_sig=1.
- Required legal ranges: 0 <= AE_LEVEL < AF_LEVEL <= DEPTH. An elaboration-time check must fail on violation.

Decomposition:
- Shared package fifo_pkg holds:
  - the count/pointer width function clog2-style helper,
  - a localparam DEPTH derivation,
  - the threshold legality check.
- One sub-module: sdp_ram, a simple dual-port register array (parameters DATA_W, ADDR_W).
  - Synchronous write port: we, waddr, wdata.
  - Asynchronous read port: raddr, rdata.
- The top level owns the pointers, flags, dout register (FWFT=0) and the FWFT mux.

Test Plan:
- Reset then idle, DATA_W=8, ADDR_W=4 -> empty_sig=1, full_sig=0, count=0, almost_empty=1, over_flow=0, dout=0.
- Fill and drain: write 0x00..0x0F over 16 cycles -> full_sig=1, count=16, almost_full from count 14. Read 16 times, FWFT=0 -> dout sequence 0x00..0x0F, each one cycle after its rd_sig, then empty_sig=1.
- Overflow protection: at full, write 0xAA -> over_flow=1, count stays 16, and the next reads return the original data with no 0xAA. err_clr=1 for one cycle -> over_flow=0.
- Underflow: empty, rd_sig=1 -> under_flow=1, rd_ptr unchanged. Then write 0x55 and read -> dout=0x55.
- Simultaneous read/write with count=5 for 40 cycles -> count stays 5, pointers wrap twice, and data order is preserved. Repeat at full and at empty: count becomes 15 and 1 respectively.
- FWFT=1: write 0x3C into empty -> dout=0x3C and empty_sig=0 the next cycle with no rd_sig. Then rd_sig -> empty_sig=1. Assert rst while count=9 -> count=0 and empty_sig=1 after that edge.
